fft_out_framer: RTL and testbench



---
 rtl/fft_out_framer.sv | 148 ++++++++++++++
 tb/tb_fft_out_framer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_framer.sv
// Output framer for the FFT reorder block: bins are indexed, SOF/EOF tagged and queued.
// Define FFT_OUT_PWR_EN to add m_pwr (re^2 + im^2) to every entry.
module fft_out_framer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LENGTH = 512,
    parameter int FIFO_DEPTH = 16,
    localparam int IDXW = $clog2(MAX_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            np,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] m_re,
    output logic [DATA_WIDTH-1:0] m_im,
    output logic [IDXW-1:0]       m_idx,
    output logic                  m_sof,
    output logic                  m_eof,
`ifdef FFT_OUT_PWR_EN
    output logic [2*DATA_WIDTH-1:0] m_pwr,
`endif
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  overflow,
    input  logic                  clr_ovf,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [DW-1:0]   re;
        logic [DW-1:0]   im;
        logic [IDXW-1:0] idx;
        logic            sof;
        logic            eof;
`ifdef FFT_OUT_PWR_EN
        logic [2*DW-1:0] pwr;
`endif
    } entry_t;

    entry_t          head_q, head_d, new_e;
    entry_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0] widx_q, widx_d, last_idx;
    logic [1:0]      np_q, np_d, np_eff;
    logic            ovf_q, ovf_d, done_q, done_d;
    logic [15:0]     fcnt_q, fcnt_d;
    logic            empty, full, push, pop, drop, to_head, mem_we;
`ifdef FFT_OUT_PWR_EN
    logic signed [2*DW-1:0] re_x, im_x;
`endif

    always_comb begin
        np_eff   = (widx_q == '0) ? np : np_q;
        last_idx = IDXW'((32'd64 << np_eff) - 32'd1);
        empty    = (cnt_q == '0);
        full     = (cnt_q == CW'(FIFO_DEPTH));
        pop      = !empty && m_ready;
        push     = in_valid && (!full || pop);
        drop     = in_valid && full && !pop;

        new_e     = '0;
        new_e.re  = in_re;
        new_e.im  = in_im;
        new_e.idx = widx_q;
        new_e.sof = (widx_q == '0);
        new_e.eof = (widx_q == last_idx);
`ifdef FFT_OUT_PWR_EN
        re_x      = {{DW{in_re[DW-1]}}, in_re};
        im_x      = {{DW{in_im[DW-1]}}, in_im};
        new_e.pwr = $unsigned(re_x * re_x + im_x * im_x);
`endif

        np_d   = np_q;
        widx_d = widx_q;
        if (in_valid) begin
            np_d   = np_eff;
            widx_d = (widx_q == last_idx) ? '0 : widx_q + 1'b1;
        end

        // The head register is fed straight from the input only when
        // nothing is waiting behind it in the storage array.
        to_head  = push && (empty || (cnt_q == CW'(1) && pop));
        mem_we   = push && !to_head;
        head_d   = head_q;
        rd_ptr_d = rd_ptr_q;
        if (pop && cnt_q > CW'(1)) begin
            head_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (to_head) begin
            head_d = new_e;
        end
        wr_ptr_d = mem_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);

        ovf_d  = (ovf_q && !clr_ovf) || drop;
        done_d = pop && head_q.eof;
        fcnt_d = fcnt_q + 16'(done_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            widx_q   <= '0;
            np_q     <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            head_q   <= head_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            np_q     <= np_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            fcnt_q   <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= new_e;
    end

    assign m_re       = head_q.re;
    assign m_im       = head_q.im;
    assign m_idx      = head_q.idx;
    assign m_sof      = head_q.sof;
    assign m_eof      = head_q.eof;
`ifdef FFT_OUT_PWR_EN
    assign m_pwr      = head_q.pwr;
`endif
    assign m_valid    = !empty;
    assign overflow   = ovf_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_fft_out_framer.sv
// Directed bench for fft_out_framer: framing, backpressure, drops, reset and power.
module tb_fft_out_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  np;
    logic [15:0] in_re, in_im;
    logic        in_valid;
    logic [15:0] m_re, m_im;
    logic [8:0]  m_idx;
    logic        m_sof, m_eof, m_valid, m_ready;
    logic        overflow, clr_ovf, frame_done;
    logic [15:0] frame_cnt;
`ifdef FFT_OUT_PWR_EN
    logic [31:0] m_pwr;
`endif

    int total = 0;
    int bad = 0;
    logic [15:0] e16;

    fft_out_framer dut (
        .clk(clk), .rst_n(rst_n), .np(np),
        .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
        .m_re(m_re), .m_im(m_im), .m_idx(m_idx),
        .m_sof(m_sof), .m_eof(m_eof),
`ifdef FFT_OUT_PWR_EN
        .m_pwr(m_pwr),
`endif
        .m_valid(m_valid), .m_ready(m_ready),
        .overflow(overflow), .clr_ovf(clr_ovf),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; m_ready = 1'b0;
        clr_ovf = 1'b0; np = 2'b00; in_re = '0; in_im = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drive(input int r, input int i);
        in_valid = 1'b1;
        in_re = 16'(r);
        in_im = 16'(i);
    endtask

    initial begin
        do_reset();
        chk("rst_valid", m_valid, 0);
        chk("rst_re", m_re, 0);
        chk("rst_idx", m_idx, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_fcnt", frame_cnt, 0);

        // contiguous 64-point frame, 1-cycle latency
        m_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            drive(k, -k);
            step();
            e16 = 16'(-k);
            chk("t1_valid", m_valid, 1);
            chk("t1_idx", m_idx, 64'(k));
            chk("t1_re", m_re, 64'(k));
            chk("t1_im", m_im, e16);
            chk("t1_sof", m_sof, (k == 0) ? 1 : 0);
            chk("t1_eof", m_eof, (k == 63) ? 1 : 0);
            chk("t1_done_lo", frame_done, 0);
        end
        in_valid = 1'b0;
        step();
        chk("t1_done", frame_done, 1);
        chk("t1_fcnt", frame_cnt, 1);
        chk("t1_empty", m_valid, 0);
        step();
        chk("t1_done_pulse", frame_done, 0);

        // backpressure with drops
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(100 + k, 0);
            step();
            chk("t2_hold_idx", m_idx, 0);
            chk("t2_hold_re", m_re, 100);
            chk("t2_ovf", overflow, (k >= 16) ? 1 : 0);
        end
        in_valid = 1'b0;
        m_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("t2_valid", m_valid, 1);
            chk("t2_idx", m_idx, 64'(j));
            chk("t2_re", m_re, 64'(100 + j));
            step();
        end
        chk("t2_drained", m_valid, 0);
        chk("t2_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t2_ovf_clr", overflow, 0);
        drive(7, 0);
        step();
        in_valid = 1'b0;
        chk("t2_next_idx", m_idx, 20);
        chk("t2_next_sof", m_sof, 0);

        // np change mid-frame takes effect on the next frame
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (k == 30) np = 2'b11;
            drive(k, 0);
            step();
            chk("t3a_idx", m_idx, 64'(k));
            chk("t3a_eof", m_eof, (k == 63) ? 1 : 0);
        end
        for (int k = 0; k < 512; k++) begin
            drive(k, 1);
            step();
            chk("t3b_idx", m_idx, 64'(k));
            chk("t3b_sof", m_sof, (k == 0) ? 1 : 0);
            chk("t3b_eof", m_eof, (k == 511) ? 1 : 0);
            if (k == 0) chk("t3_fcnt1", frame_cnt, 1);
        end
        in_valid = 1'b0;
        step();
        chk("t3_done", frame_done, 1);
        chk("t3_fcnt2", frame_cnt, 2);

        // push and pop together at full
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(k, 0);
            step();
        end
        chk("t4_full_ovf", overflow, 0);
        chk("t4_head", m_idx, 0);
        m_ready = 1'b1;
        drive(16, 0);
        step();
        chk("t4_nodrop", overflow, 0);
        chk("t4_head1", m_idx, 1);
        m_ready = 1'b0;
        drive(17, 0);
        step();
        chk("t4_still_full", overflow, 1);
        clr_ovf = 1'b1;
        drive(18, 0);
        step();
        chk("t4_clr_drop", overflow, 1);
        in_valid = 1'b0;
        step();
        clr_ovf = 1'b0;
        chk("t4_clr", overflow, 0);
        m_ready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            chk("t4_drain_idx", m_idx, 64'(j));
            step();
        end
        chk("t4_empty", m_valid, 0);

        // async reset mid-frame
        do_reset();
        np = 2'b10;
        m_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            drive(k + 1, k + 1);
            step();
        end
        chk("t5_pre_idx", m_idx, 99);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_rst_valid", m_valid, 0);
        chk("t5_rst_re", m_re, 0);
        chk("t5_rst_im", m_im, 0);
        chk("t5_rst_idx", m_idx, 0);
        chk("t5_rst_ovf", overflow, 0);
        chk("t5_rst_fcnt", frame_cnt, 0);
        np = 2'b01;
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 128; k++) begin
            drive(k, 0);
            step();
            chk("t5_idx", m_idx, 64'(k));
            chk("t5_sof", m_sof, (k == 0) ? 1 : 0);
            chk("t5_eof", m_eof, (k == 127) ? 1 : 0);
        end
        in_valid = 1'b0;
        step();
        chk("t5_fcnt", frame_cnt, 1);

`ifdef FFT_OUT_PWR_EN
        do_reset();
        m_ready = 1'b1;
        drive(3, -4);
        step();
        chk("t6_pwr25", m_pwr, 25);
        drive(-32768, -32768);
        step();
        chk("t6_pwr_fs", m_pwr, 64'h8000_0000);
        drive(0, 0);
        step();
        chk("t6_pwr0", m_pwr, 0);
        in_valid = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
